mem_ctrl: RTL

- Memory controller directly downstream of the store/load buffer; also serves the instruction-fetch unit.
- Accepts single-cycle load/store pulses from the store/load buffer and level-held fetch requests.
- Serialises each access onto the 8-bit synchronous RAM port, one byte per cycle, little-endian.
- Returns raw zero-extended load data or instruction words with one-cycle done pulses; load sign/zero extension stays in the store/load buffer.

---
 rtl/mem_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller for the store/load buffer and instruction fetch.
// Define IO_STALL_EN to hold IO-region accesses while the UART buffer is full.
module mem_ctrl #(
    parameter int         TYPE_W = 6,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear_flag,
    input  logic              slb_load_req,
    input  logic              slb_store_req,
    input  logic [TYPE_W-1:0] slb_ordertype,
    input  logic [31:0]       slb_vj,
    input  logic [31:0]       slb_vk,
    input  logic [31:0]       slb_a,
    output logic              slb_data_ok,
    output logic [31:0]       slb_data_ans,
    input  logic              if_req,
    input  logic [31:0]       if_pc,
    output logic              if_ok,
    output logic [31:0]       if_inst,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [31:0]       mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    localparam logic [TYPE_W-1:0] OP_LB  = TYPE_W'(11);
    localparam logic [TYPE_W-1:0] OP_LH  = TYPE_W'(12);
    localparam logic [TYPE_W-1:0] OP_LBU = TYPE_W'(14);
    localparam logic [TYPE_W-1:0] OP_LHU = TYPE_W'(15);
    localparam logic [TYPE_W-1:0] OP_SB  = TYPE_W'(16);
    localparam logic [TYPE_W-1:0] OP_SH  = TYPE_W'(17);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t      state, next_state;

    // current transaction; last = byte count - 1
    logic [2:0]  cnt;
    logic [1:0]  ccnt;
    logic        issued;
    logic [1:0]  last;
    logic        is_fetch;
    logic        squash;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic        pend_vld;
    logic        pend_store;
    logic        pend_squash;
    logic [1:0]  pend_last;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;

    logic        slb_ok_q;
    logic        if_ok_q;

    logic        idle, live, live_store, take_pend, take_live, take_if, accept, live_to_pend;
    logic        acc_store, acc_fetch, acc_squash;
    logic [1:0]  acc_last;
    logic [31:0] acc_addr, acc_data;
    logic [31:0] cur_addr;
    logic [31:0] rdata_next;
    logic        io_stall, issue, rd_done, wr_step, wr_done;

    function automatic logic [1:0] size_last(input logic [TYPE_W-1:0] t);
        case (t)
            OP_LB, OP_LBU, OP_SB: size_last = 2'd0;
            OP_LH, OP_LHU, OP_SH: size_last = 2'd1;
            default:              size_last = 2'd3;
        endcase
    endfunction

    assign cur_addr = base + 32'(cnt);

`ifdef IO_STALL_EN
    assign io_stall = (cur_addr[17:16] == IO_HI) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full ^ (^IO_HI);
    assign io_stall  = 1'b0;
`endif

    always_comb begin
        issue      = (state == RD) && (cnt <= {1'b0, last}) && !io_stall;
        rd_done    = (state == RD) && issued && (ccnt == last) && !clear_flag;
        wr_step    = (state == WR) && !io_stall;
        wr_done    = wr_step && (cnt[1:0] == last);
        rdata_next = rdata;
        rdata_next[{ccnt, 3'b000} +: 8] = mem_din;
    end

    // Accept arbitration: pending slot, then live SLB pulse, then fetch.
    // A fetch is not re-accepted while its own if_ok is on the wire.
    always_comb begin
        idle         = (state == IDLE);
        live_store   = slb_store_req && !slb_load_req;
        live         = (slb_load_req || slb_store_req) && !clear_flag;
        take_pend    = idle && pend_vld && (pend_store || !clear_flag);
        take_live    = idle && !take_pend && live;
        take_if      = idle && !take_pend && !live && if_req && !clear_flag && !if_ok_q;
        accept       = take_pend || take_live || take_if;
        live_to_pend = live && !take_live;

        acc_store  = 1'b0;
        acc_fetch  = 1'b1;
        acc_squash = 1'b0;
        acc_last   = 2'd3;
        acc_addr   = if_pc;
        acc_data   = 32'd0;
        if (take_pend) begin
            acc_store  = pend_store;
            acc_fetch  = 1'b0;
            acc_squash = pend_squash || clear_flag;
            acc_last   = pend_last;
            acc_addr   = pend_addr;
            acc_data   = pend_data;
        end else if (take_live) begin
            acc_store  = live_store;
            acc_fetch  = 1'b0;
            acc_last   = size_last(slb_ordertype);
            acc_addr   = slb_vj + slb_a;
            acc_data   = slb_vk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (rdy) begin
            case (state)
                IDLE:    if (accept) next_state = acc_store ? WR : RD;
                RD:      if (clear_flag || rd_done) next_state = IDLE;
                WR:      if (wr_done) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // While frozen mid-read, re-present the last issued address so the
    // byte is still on mem_din when capture resumes.
    always_comb begin
        mem_a = 32'd0;
        if (state == RD && !rdy && issued) mem_a = cur_addr - 32'd1;
        else if (state == WR || issue)     mem_a = cur_addr;
        mem_wr      = (state == WR) && rdy && !io_stall;
        mem_dout    = (state == WR) ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'd0;
        slb_data_ok = slb_ok_q && rdy;
        if_ok       = if_ok_q && rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 3'd0;
            ccnt         <= 2'd0;
            issued       <= 1'b0;
            last         <= 2'd0;
            is_fetch     <= 1'b0;
            squash       <= 1'b0;
            pend_vld     <= 1'b0;
            pend_store   <= 1'b0;
            pend_squash  <= 1'b0;
            pend_last    <= 2'd0;
            slb_ok_q     <= 1'b0;
            if_ok_q      <= 1'b0;
            slb_data_ans <= 32'd0;
            if_inst      <= 32'd0;
        end else if (rdy) begin
            slb_ok_q <= 1'b0;
            if_ok_q  <= 1'b0;
            if (accept) begin
                cnt      <= 3'd0;
                ccnt     <= 2'd0;
                issued   <= 1'b0;
                last     <= acc_last;
                is_fetch <= acc_fetch;
                squash   <= acc_squash;
            end else if (state == RD) begin
                cnt    <= cnt + 3'(issue);
                issued <= issue;
                if (issued) ccnt <= ccnt + 2'd1;
            end else if (wr_step) begin
                cnt <= cnt + 3'd1;
            end
            if (state == WR && clear_flag) squash <= 1'b1;
            if (rd_done) begin
                if (is_fetch) begin
                    if_ok_q <= 1'b1;
                    if_inst <= rdata_next;
                end else begin
                    slb_ok_q     <= 1'b1;
                    slb_data_ans <= rdata_next;
                end
            end
            if (wr_done && !squash && !clear_flag) slb_ok_q <= 1'b1;

            if (take_pend || (clear_flag && !pend_store)) pend_vld <= 1'b0;
            if (live_to_pend) begin
                pend_vld    <= 1'b1;
                pend_store  <= live_store;
                pend_last   <= size_last(slb_ordertype);
                pend_squash <= 1'b0;
            end else if (clear_flag && pend_store) begin
                pend_squash <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (accept) begin
                base  <= acc_addr;
                wdata <= acc_data;
                rdata <= 32'd0;
            end else if (state == RD && issued) begin
                rdata <= rdata_next;
            end
            if (live_to_pend) begin
                pend_addr <= slb_vj + slb_a;
                pend_data <= slb_vk;
            end
        end
    end

endmodule
